// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port between the IF-stage fetch and the MEM-stage load/store.
// Only one transaction is in flight at a time, and each response returns to the requester that owns it.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_b_en,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        ram_req,
  output logic        ram_wr,
  output logic [3:0]  ram_b_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_addr_ok,
  input  logic        ram_data_ok,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = fetch, 1 = load/store
  logic        wr_q, wr_d;
  logic [3:0]  b_en_q, b_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        live_q;             // low for the first cycle after reset release
  logic        grant_inst, grant_data;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    b_en_d       = b_en_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_cnt_d = starve_cnt_q;
    grant_inst   = 1'b0;
    grant_data   = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    ram_req      = 1'b0;
    ram_wr       = 1'b0;
    ram_b_en     = 4'b0000;
    ram_addr     = 32'h0;
    ram_wdata    = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (live_q) begin
          // A starved fetch overrides the default preference for the data side.
          if (inst_req && (!data_req || starve_cnt_q >= STARVE_LIM)) begin
            grant_inst = 1'b1;
          end else if (data_req) begin
            grant_data = 1'b1;
          end
        end
        if (grant_inst) begin
          inst_addr_ok = 1'b1;
          owner_d      = 1'b0;
          wr_d         = 1'b0;
          b_en_d       = 4'b0000;
          addr_d       = inst_addr;
          wdata_d      = 32'h0;
          starve_cnt_d = 4'd0;
          state_d      = REQ;
        end else if (grant_data) begin
          data_addr_ok = 1'b1;
          owner_d      = 1'b1;
          wr_d         = data_wr;
          b_en_d       = data_wr ? data_b_en : 4'b0000;
          addr_d       = data_addr;
          wdata_d      = data_wdata;
          if (inst_req && starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
          state_d      = REQ;
        end
      end

      REQ: begin
        ram_req   = 1'b1;
        ram_wr    = wr_q;
        ram_b_en  = b_en_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (ram_addr_ok) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (ram_data_ok) begin
          if (owner_q) begin
            data_data_ok = 1'b1;
            data_rdata   = ram_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = ram_rdata;
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      b_en_q       <= 4'b0000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      starve_cnt_q <= 4'd0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      b_en_q       <= b_en_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
      live_q       <= 1'b1;
    end
  end

endmodule
